sign_contract: RTL and testbench
================================

Name: sign_contract

Overview:
- Pipelined narrowing unit. Inverse of the datapath's sign/zero extender: it takes a WIDTH_IN-bit value and produces a WIDTH_OUT-bit value.
- Flags any value not representable in the narrow width, as signed or unsigned. Optionally saturates such values instead of truncating.
- Sits between the 64-bit ALU/register path and narrow consumers (STURB/STURH/STURW store data, immediate-range checks).
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH_IN, 64, input data width.
- WIDTH_OUT, 26, output data width; must satisfy 2 <= WIDTH_OUT < WIDTH_IN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH_IN  value to narrow.
- sign  input  1  1 = signed (two's-complement) range check, 0 = unsigned.
- sat  input  1  1 = saturate on overflow, 0 = truncate.
- in_valid  input  1  producer has a transaction on in/sign/sat.
- in_ready  output  1  unit accepts the transaction this cycle.
- out  output  WIDTH_OUT  narrowed result.
- ovf  output  1  result for this transaction did not fit.
- out_valid  output  1  out/ovf hold a valid transaction.
- out_ready  input  1  consumer takes out/ovf this cycle.
- clr_sticky  input  1  clears ovf_sticky and ovf_count.
- ovf_sticky  output  1  set once any overflowed result has been delivered.
- ovf_count  output  16  number of overflowed results delivered, saturating.

Behaviour:
- Reset: clk edge with reset=1 clears every pipeline valid bit.
  - Data registers, out, ovf, ovf_sticky and ovf_count all go to 0.
  - in_ready is forced to 0 while reset=1.
  - Reset mid-operation discards all in-flight transactions; none is delivered.
- Transfers:
  - Input transfer = in_valid && in_ready at a clk edge.
  - Output transfer = out_valid && out_ready at a clk edge.
- Pipeline: two register stages, A (captured operands) then B (computed result). out/ovf/out_valid come directly from stage B registers.
  - Latency: a transaction accepted at edge N is presented with out_valid=1 after edge N+1, i.e. two edges after acceptance.
  - Throughput is one transaction per cycle when out_ready=1.
- Ready / stall rules:
  - B advances (loads from A, or clears its valid bit) when !B_valid || out_ready.
  - A advances when !A_valid || B advances.
  - in_ready = !reset && A advances. This is a combinational path from out_ready.
  - A stalled stage holds its contents unchanged. Transactions are never dropped, duplicated or reordered.
- Fit check, computed from stage A contents:
  - sign=1: fits iff in[WIDTH_IN-1:WIDTH_OUT-1] are all equal.
  - sign=0: fits iff in[WIDTH_IN-1:WIDTH_OUT] are all zero.
- Result loaded into B:
  - If fits: out = in[WIDTH_OUT-1:0], ovf = 0.
  - If not fits and sat=0: out = in[WIDTH_OUT-1:0], ovf = 1.
  - If not fits, sat=1, sign=1: in[WIDTH_IN-1]=0 gives max positive {0, all ones}; in[WIDTH_IN-1]=1 gives min negative {1, all zeros}. ovf = 1.
  - If not fits, sat=1, sign=0: out = all ones, ovf = 1.
- Sticky flag and counter: an overflow event is an output transfer with ovf=1.
  - On an event, ovf_sticky is set to 1 and ovf_count increments, holding at 16'hFFFF.
  - clr_sticky=1 with no event: ovf_sticky becomes 0 and ovf_count becomes 0.
  - clr_sticky=1 with an event in the same cycle: ovf_sticky becomes 1 and ovf_count becomes 1 (clear first, then count).
- sign and sat are sampled per transaction. Changing them while a transaction is stalled in A has no effect on that transaction.

Test Plan (bench instance WIDTH_IN=8, WIDTH_OUT=4):
- Signed fits / overflow: in=8'hF9 sign=1 sat=0 gives out=4'h9, ovf=0. in=8'h09 sign=1 sat=0 gives out=4'h9, ovf=1. in=8'h09 sign=1 sat=1 gives out=4'h7, ovf=1. in=8'h80 sign=1 sat=1 gives out=4'h8, ovf=1.
- Unsigned: in=8'h0F sign=0 gives out=4'hF, ovf=0. in=8'h10 sat=0 gives out=4'h0, ovf=1. in=8'h10 sat=1 gives out=4'hF, ovf=1.
- Streaming and latency: out_ready=1, in_valid=1 for 5 consecutive cycles with in=8'h01..8'h05 sign=0 gives out_valid rising two edges after the first acceptance, then outs 1..5 on consecutive cycles with in_ready held at 1.
- Backpressure: same stream with out_ready=0 for 4 cycles.
  - in_ready drops after both stages fill, so exactly 2 transactions are held.
  - out stays 4'h1 during the stall.
  - Release delivers 1..5 in order with no loss or duplicates.
- Sticky and counter:
  - Deliver 3 overflowing results: ovf_sticky=1, ovf_count=3.
  - Assert clr_sticky with no event: both become 0.
  - Assert clr_sticky in the same cycle as an overflow delivery: ovf_sticky=1, ovf_count=1.
- Reset mid-operation: two transactions in flight with out_ready=0, then reset=1 for one edge. After that edge out_valid=0, out=0, ovf_count=0 and in_ready=0 while reset=1. After reset falls, no stale transaction ever appears at out.

Source files
------------

// File: rtl/sign_contract_if.sv
// rtl/sign_contract_if.sv - Producer/consumer handshake bundle for the narrowing unit.
interface sign_contract_if #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_OUT = 26
);
    logic [WIDTH_IN-1:0]  in;
    logic                 sign;
    logic                 sat;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH_OUT-1:0] out;
    logic                 ovf;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in, sign, sat, in_valid, out_ready,
        input  in_ready, out, ovf, out_valid
    );

    modport slave (
        input  in, sign, sat, in_valid, out_ready,
        output in_ready, out, ovf, out_valid
    );
endinterface

// File: rtl/sign_contract.sv
// rtl/sign_contract.sv - Two-stage narrowing unit with signed/unsigned range check,
// optional saturation and sticky overflow statistics.
module sign_contract #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_OUT = 26
) (
    input  logic        clk,
    input  logic        reset,
    sign_contract_if.slave bus,
    input  logic        clr_sticky,
    output logic        ovf_sticky,
    output logic [15:0] ovf_count
);
    localparam logic [WIDTH_OUT-1:0] SAT_POS = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] SAT_NEG = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    localparam logic [WIDTH_OUT-1:0] SAT_U   = {WIDTH_OUT{1'b1}};

    logic                 a_valid;
    logic [WIDTH_IN-1:0]  a_data;
    logic                 a_sign;
    logic                 a_sat;
    logic                 b_valid;
    logic [WIDTH_OUT-1:0] b_out;
    logic                 b_ovf;

    logic                 b_adv;
    logic                 a_adv;
    logic                 fits;
    logic                 ovf_event;
    logic [WIDTH_OUT-1:0] result;

    assign b_adv = !b_valid || bus.out_ready;
    assign a_adv = !a_valid || b_adv;

    assign bus.in_ready  = !reset && a_adv;
    assign bus.out       = b_out;
    assign bus.ovf       = b_ovf;
    assign bus.out_valid = b_valid;

    // Signed: the bits above the narrow sign bit must replicate it.
    always_comb begin
        fits   = 1'b0;
        result = a_data[WIDTH_OUT-1:0];
        if (a_sign) begin
            fits = (&a_data[WIDTH_IN-1:WIDTH_OUT-1]) || !(|a_data[WIDTH_IN-1:WIDTH_OUT-1]);
        end else begin
            fits = !(|a_data[WIDTH_IN-1:WIDTH_OUT]);
        end
        if (!fits && a_sat) begin
            if (a_sign) begin
                result = a_data[WIDTH_IN-1] ? SAT_NEG : SAT_POS;
            end else begin
                result = SAT_U;
            end
        end
    end

    assign ovf_event = b_valid && bus.out_ready && b_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_data  <= '0;
            a_sign  <= 1'b0;
            a_sat   <= 1'b0;
            b_valid <= 1'b0;
            b_out   <= '0;
            b_ovf   <= 1'b0;
        end else begin
            if (b_adv) begin
                b_valid <= a_valid;
                if (a_valid) begin
                    b_out <= result;
                    b_ovf <= !fits;
                end
            end
            if (a_adv) begin
                a_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    a_data <= bus.in;
                    a_sign <= bus.sign;
                    a_sat  <= bus.sat;
                end
            end
        end
    end

    // A clear in the same cycle as an overflow delivery clears first, then counts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= 16'd0;
        end else if (clr_sticky) begin
            ovf_sticky <= ovf_event;
            ovf_count  <= ovf_event ? 16'd1 : 16'd0;
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != 16'hFFFF) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sign_contract.sv
// tb/tb_sign_contract.sv - Self-checking bench for sign_contract (WIDTH_IN=8, WIDTH_OUT=4).
module tb_sign_contract;
    localparam int WI = 8;
    localparam int WO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr_sticky = 1'b0;
    logic        ovf_sticky;
    logic [15:0] ovf_count;

    sign_contract_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

    sign_contract #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [4:0]  exp_q[$];
    logic        m_sticky = 1'b0;
    logic [15:0] m_count  = 16'd0;

    logic       acc, dlv, ov;
    logic [3:0] o;
    logic [4:0] ex;

    // Reference: {ovf, out} from the numeric range of the narrow type.
    function automatic logic [4:0] ref_model(input logic [7:0] d, input logic s, input logic st);
        int v, lo, hi;
        if (s) begin
            v  = int'($signed(d));
            lo = -8;
            hi = 7;
        end else begin
            v  = int'(d);
            lo = 0;
            hi = 15;
        end
        if (v >= lo && v <= hi) return {1'b0, d[3:0]};
        if (!st) return {1'b1, d[3:0]};
        if (v > hi) return {1'b1, hi[3:0]};
        return {1'b1, lo[3:0]};
    endfunction

    task automatic step(input logic rst, input logic iv, input logic [7:0] d, input logic s,
                        input logic st, input logic ordy, input logic clr);
        logic evt;
        @(negedge clk);
        reset         = rst;
        bus.in_valid  = iv;
        bus.in        = d;
        bus.sign      = s;
        bus.sat       = st;
        bus.out_ready = ordy;
        clr_sticky    = clr;
        #1;
        acc = iv && bus.in_ready;
        dlv = !rst && bus.out_valid && ordy;
        o   = bus.out;
        ov  = bus.ovf;
        ex  = 'x;
        evt = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_sticky = 1'b0;
            m_count  = 16'd0;
        end else begin
            if (dlv) begin
                if (exp_q.size() > 0) ex = exp_q.pop_front();
                evt = (ex[4] === 1'b1);
            end
            if (acc) exp_q.push_back(ref_model(d, s, st));
            if (clr) begin
                m_sticky = evt;
                m_count  = evt ? 16'd1 : 16'd0;
            end else if (evt) begin
                m_sticky = 1'b1;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 8'h00, 0, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out !== 4'h0) $display("FAIL reset_out: got %h want 0", bus.out); else passed++;
        total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf); else passed++;
        total++; if (ovf_sticky !== 1'b0) $display("FAIL reset_sticky: got %b want 0", ovf_sticky); else passed++;
        total++; if (ovf_count !== 16'd0) $display("FAIL reset_count: got %h want 0", ovf_count); else passed++;
    endtask

    task automatic test_directed();
        logic [7:0] td [7];
        logic       ts [7];
        logic       tt [7];
        logic [4:0] tr [7];
        bit         got;
        td = '{8'hF9, 8'h09, 8'h09, 8'h80, 8'h0F, 8'h10, 8'h10};
        ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tt = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tr = '{5'h09, 5'h19, 5'h17, 5'h18, 5'h0F, 5'h10, 5'h1F};
        for (int i = 0; i < 7; i++) begin
            step(0, 1, td[i], ts[i], tt[i], 1, 0);
            total++; if (acc !== 1'b1) $display("FAIL directed_accept[%0d]: got %b want 1", i, acc); else passed++;
            got = 0;
            for (int k = 0; k < 5 && !got; k++) begin
                step(0, 0, 8'h00, 0, 0, 1, 0);
                if (dlv) begin
                    got = 1;
                    total++;
                    if ({ov, o} !== tr[i])
                        $display("FAIL directed[%0d] in=%h: got ovf=%b out=%h want ovf=%b out=%h", i, td[i], ov, o, tr[i][4], tr[i][3:0]);
                    else passed++;
                    total++; if ({ov, o} !== ex) $display("FAIL directed_model[%0d]: got %h want %h", i, {ov, o}, ex); else passed++;
                end
            end
            if (!got) begin
                total++;
                $display("FAIL directed_timeout[%0d]: got no delivery want one", i);
            end
        end
    endtask

    task automatic test_streaming();
        int n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, i < 5, 8'(i + 1), 0, 0, 1, 0);
            if (i < 5) begin
                total++; if (acc !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, acc); else passed++;
            end
            if (dlv) begin
                total++;
                if (i != n + 2 || o !== 4'(n + 1))
                    $display("FAIL stream_out: got out=%h at step %0d want out=%h at step %0d", o, i, 4'(n + 1), n + 2);
                else passed++;
                n++;
            end
        end
        total++; if (n != 5) $display("FAIL stream_count: got %0d want 5", n); else passed++;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int n = 0;
        logic [3:0] got [8];
        for (int i = 0; i < 4; i++) begin
            step(0, idx < 5, 8'(idx + 1), 0, 0, 0, 0);
            if (acc) idx++;
            if (i >= 2) begin
                total++; if (acc !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, acc); else passed++;
                total++; if (o !== 4'h1) $display("FAIL bp_hold_out[%0d]: got %h want 1", i, o); else passed++;
            end
        end
        total++; if (idx != 2) $display("FAIL bp_held: got %0d want 2", idx); else passed++;
        for (int i = 0; i < 12; i++) begin
            step(0, idx < 5, 8'(idx + 1), 0, 0, 1, 0);
            if (acc) idx++;
            if (dlv) begin
                if (n < 8) got[n] = o;
                n++;
            end
        end
        total++; if (n != 5) $display("FAIL bp_count: got %0d want 5", n); else passed++;
        for (int j = 0; j < 5 && j < n; j++) begin
            total++; if (got[j] !== 4'(j + 1)) $display("FAIL bp_order[%0d]: got %h want %h", j, got[j], 4'(j + 1)); else passed++;
        end
    endtask

    task automatic test_sticky();
        step(0, 0, 8'h00, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 8'h10, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 0, 0, 1, 0);
        total++; if (ovf_sticky !== 1'b1) $display("FAIL sticky_set: got %b want 1", ovf_sticky); else passed++;
        total++; if (ovf_count !== 16'd3) $display("FAIL count_3: got %0d want 3", ovf_count); else passed++;
        step(0, 0, 8'h00, 0, 0, 1, 1);
        total++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_clr: got %b want 0", ovf_sticky); else passed++;
        total++; if (ovf_count !== 16'd0) $display("FAIL count_clr: got %0d want 0", ovf_count); else passed++;
        step(0, 1, 8'h10, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1, 1);
        total++; if (dlv !== 1'b1) $display("FAIL clr_event_dlv: got %b want 1", dlv); else passed++;
        total++; if (ovf_sticky !== 1'b1) $display("FAIL clr_event_sticky: got %b want 1", ovf_sticky); else passed++;
        total++; if (ovf_count !== 16'd1) $display("FAIL clr_event_count: got %0d want 1", ovf_count); else passed++;
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        step(0, 1, 8'h03, 0, 0, 0, 0);
        step(0, 1, 8'h1F, 0, 1, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out !== 4'h0) $display("FAIL rst_mid_out: got %h want 0", bus.out); else passed++;
        total++; if (ovf_count !== 16'd0) $display("FAIL rst_mid_count: got %0d want 0", ovf_count); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %b want 0", bus.in_ready); else passed++;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 8'h00, 0, 0, 1, 0);
            if (bus.out_valid !== 1'b0) stale++;
        end
        total++; if (stale != 0) $display("FAIL rst_mid_stale: got %0d stale cycles want 0", stale); else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            step(0, $urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            if (dlv) begin
                total++;
                if ({ov, o} !== ex) begin
                    errs++;
                    if (errs < 10) $display("FAIL random_data[%0d]: got %h want %h", i, {ov, o}, ex);
                end else passed++;
            end
            total++;
            if (ovf_sticky !== m_sticky || ovf_count !== m_count) begin
                errs++;
                if (errs < 10) $display("FAIL random_stats[%0d]: got %b/%0d want %b/%0d", i, ovf_sticky, ovf_count, m_sticky, m_count);
            end else passed++;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 0, 1, 0);
        total++; if (exp_q.size() != 0) $display("FAIL random_drain: got %0d pending want 0", exp_q.size()); else passed++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.sign      = 1'b0;
        bus.sat       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_streaming();
        test_backpressure();
        test_sticky();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
